// File: rtl/cache_controller_pkg.sv
// Shared definitions for the MEM-stage cache controller and its neighbours
// (2-way data cache, SRAM controller).
//   - CACHE_BASE_ADDR : byte offset removed from CPU addresses before word conversion
//   - CACHE_ADDR_W    : word-address width used by the cache and the SRAM controller
//   - DATA_W          : CPU data / address width
//   - state_t         : controller state encoding (IDLE=0, READ_MISS=1, WRITE=2, DONE=3)
package cache_controller_pkg;

  localparam int unsigned CACHE_BASE_ADDR = 1024;
  localparam int unsigned CACHE_ADDR_W    = 18;
  localparam int unsigned DATA_W          = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears to zero)
//   i_inc     : count enable, one increment per cycle
//   o_count   : current count
module cache_controller_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Hold at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_controller.sv
// MEM-stage cache controller: read hits served from the cache in the same
// cycle, read misses fetched from SRAM and filled into the cache, stores
// written through to SRAM with the cached copy invalidated on a hit.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mem_r_en, mem_w_en  : load / store request from MEM stage (store wins)
//   address, wdata      : CPU byte address and store data
//   rdata, ready        : load data to WB, 0 = freeze pipeline
//   cache_*             : read (LRU), fill, invalidate, word address, fill data,
//                         hit and read data from the cache
//   sram_*              : read / write request (held until sram_ready),
//                         word address, write data, read data, completion pulse
//   hit_count, miss_count : saturating read hit / miss counters
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR = CACHE_BASE_ADDR,
  parameter int unsigned ADDR_W    = CACHE_ADDR_W,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              cache_rd_en,
  output logic              cache_wr_en,
  output logic              cache_invalidate,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  state_t            r_state;
  logic [DATA_W-1:0] r_rdata;

  logic [DATA_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_word;
  logic              w_idle;
  logic              w_rd_req;
  logic              w_rd_hit;
  logic              w_rd_miss;
  logic              w_unused_offset;

  // Byte address -> word address relative to BASE_ADDR
  assign w_offset        = address - DATA_W'(BASE_ADDR);
  assign w_word          = w_offset[ADDR_W+1:2];
  assign w_unused_offset = ^{w_offset[DATA_W-1:ADDR_W+2], w_offset[1:0]};

  assign cache_address = w_word;
  assign sram_address  = w_word;
  assign sram_wdata    = wdata;
  assign cache_wdata   = sram_rdata;

  // A store takes priority, so a read only counts when no store is present
  assign w_idle    = (r_state == IDLE);
  assign w_rd_req  = mem_r_en && !mem_w_en;
  assign w_rd_hit  = w_idle && w_rd_req && cache_hit;
  assign w_rd_miss = w_idle && w_rd_req && !cache_hit;

  // State and load-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_w_en) begin
            r_state <= WRITE;
          end else if (w_rd_miss) begin
            r_state <= READ_MISS;
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            r_rdata <= sram_rdata;
            r_state <= DONE;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake decode; hits must answer in the same cycle, so these follow inputs
  always_comb begin
    ready            = 1'b0;
    cache_rd_en      = 1'b0;
    cache_wr_en      = 1'b0;
    cache_invalidate = 1'b0;
    sram_rd_en       = 1'b0;
    sram_wr_en       = 1'b0;
    case (r_state)
      IDLE: begin
        ready            = !(mem_w_en || w_rd_miss);
        cache_rd_en      = w_rd_hit;
        cache_invalidate = mem_w_en && cache_hit;
      end
      READ_MISS: begin
        sram_rd_en  = 1'b1;
        cache_wr_en = sram_ready;
      end
      WRITE: begin
        sram_wr_en = 1'b1;
      end
      DONE: begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // Hit data bypasses the register; otherwise present the last filled word
  assign rdata = w_rd_hit ? cache_rdata : r_rdata;

  cache_controller_sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_rd_hit),
    .o_count (hit_count)
  );

  cache_controller_sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_rd_miss),
    .o_count (miss_count)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a small direct-mapped cache model
// answers lookups, the stimulus tasks play the SRAM, and a transaction-level
// model predicts every handshake output each cycle.
module tb_cache_controller;

  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_r_en, mem_w_en;
  logic [31:0]   address, wdata, rdata;
  logic          ready;
  logic          cache_rd_en, cache_wr_en, cache_invalidate;
  logic [AW-1:0] cache_address;
  logic [31:0]   cache_wdata;
  logic          cache_hit;
  logic [31:0]   cache_rdata;
  logic          sram_rd_en, sram_wr_en;
  logic [AW-1:0] sram_address;
  logic [31:0]   sram_wdata, sram_rdata;
  logic          sram_ready;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cache_controller #(.BASE_ADDR(BASE), .ADDR_W(AW), .CNT_W(CW)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .mem_r_en         (mem_r_en),
    .mem_w_en         (mem_w_en),
    .address          (address),
    .wdata            (wdata),
    .rdata            (rdata),
    .ready            (ready),
    .cache_rd_en      (cache_rd_en),
    .cache_wr_en      (cache_wr_en),
    .cache_invalidate (cache_invalidate),
    .cache_address    (cache_address),
    .cache_wdata      (cache_wdata),
    .cache_hit        (cache_hit),
    .cache_rdata      (cache_rdata),
    .sram_rd_en       (sram_rd_en),
    .sram_wr_en       (sram_wr_en),
    .sram_address     (sram_address),
    .sram_wdata       (sram_wdata),
    .sram_rdata       (sram_rdata),
    .sram_ready       (sram_ready),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return AW'(off >> 2);
  endfunction

  // Four-entry direct-mapped cache standing in for the real 2-way cache
  logic          bc_v    [4] = '{default: 1'b0};
  logic [AW-1:0] bc_tag  [4] = '{default: '0};
  logic [31:0]   bc_data [4] = '{default: '0};
  logic [AW-1:0] tb_word;

  assign tb_word     = word_of(address);
  assign cache_hit   = bc_v[tb_word[1:0]] && (bc_tag[tb_word[1:0]] == tb_word);
  assign cache_rdata = bc_data[tb_word[1:0]];

  function automatic bit bc_lookup(input logic [AW-1:0] wa);
    return bc_v[wa[1:0]] && (bc_tag[wa[1:0]] == wa);
  endfunction

  always @(posedge clk) begin
    if (cache_wr_en) begin
      bc_v[cache_address[1:0]]    <= 1'b1;
      bc_tag[cache_address[1:0]]  <= cache_address;
      bc_data[cache_address[1:0]] <= cache_wdata;
    end
    if (cache_invalidate && bc_lookup(cache_address)) begin
      bc_v[cache_address[1:0]] <= 1'b0;
    end
  end

  // Transaction model: waiting on SRAM for a read or a write, then one done cycle
  bit          m_wait_rd = 0, m_wait_wr = 0, m_done = 0, m_done_rd = 0;
  int          m_hits = 0, m_misses = 0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_wait_rd = 0; m_wait_wr = 0; m_done = 0; m_done_rd = 0;
      m_hits = 0; m_misses = 0; m_rdata = '0;
    end else if (m_done) begin
      m_done = 0; m_done_rd = 0;
    end else if (m_wait_rd) begin
      if (sram_ready) begin
        m_rdata = sram_rdata; m_wait_rd = 0; m_done = 1; m_done_rd = 1;
      end
    end else if (m_wait_wr) begin
      if (sram_ready) begin
        m_wait_wr = 0; m_done = 1;
      end
    end else if (mem_w_en) begin
      m_wait_wr = 1;
    end else if (mem_r_en) begin
      if (cache_hit) begin
        if (m_hits < MAXC) m_hits++;
      end else begin
        if (m_misses < MAXC) m_misses++;
        m_wait_rd = 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit idle, rdq, e_crd;
    if (chk_on) begin
      idle  = !(m_wait_rd || m_wait_wr || m_done);
      rdq   = mem_r_en && !mem_w_en;
      e_crd = idle && rdq && cache_hit;
      chk("ready", 32'(ready),
          32'(idle ? !(mem_w_en || (rdq && !cache_hit)) : m_done));
      chk("cache_rd_en", 32'(cache_rd_en), 32'(e_crd));
      chk("cache_invalidate", 32'(cache_invalidate), 32'(idle && mem_w_en && cache_hit));
      chk("cache_wr_en", 32'(cache_wr_en), 32'(m_wait_rd && sram_ready));
      chk("sram_rd_en", 32'(sram_rd_en), 32'(m_wait_rd));
      chk("sram_wr_en", 32'(sram_wr_en), 32'(m_wait_wr));
      chk("cache_address", 32'(cache_address), 32'(word_of(address)));
      chk("sram_address", 32'(sram_address), 32'(word_of(address)));
      chk("sram_wdata", sram_wdata, wdata);
      chk("cache_wdata", cache_wdata, sram_rdata);
      chk("hit_count", 32'(hit_count), 32'(m_hits));
      chk("miss_count", 32'(miss_count), 32'(m_misses));
      if (e_crd) chk("rdata_hit", rdata, cache_rdata);
      else if (m_done && m_done_rd) chk("rdata_done", rdata, m_rdata);
    end
  end

  // Pulse/cycle tallies for the hand-computed expectations
  int          n_crd, n_inv, n_cwr, n_srd, n_swr;
  logic [31:0] last_cwdata, last_saddr, last_swdata;

  always @(negedge clk) begin
    if (chk_on) begin
      if (cache_rd_en) n_crd++;
      if (cache_invalidate) n_inv++;
      if (cache_wr_en) begin n_cwr++; last_cwdata = cache_wdata; end
      if (sram_rd_en) begin n_srd++; last_saddr = 32'(sram_address); end
      if (sram_wr_en) begin n_swr++; last_saddr = 32'(sram_address); last_swdata = sram_wdata; end
    end
  end

  task automatic reset_mon();
    n_crd = 0; n_inv = 0; n_cwr = 0; n_srd = 0; n_swr = 0;
    last_cwdata = '0; last_saddr = '0; last_swdata = '0;
  endtask

  // One request; SRAM answers in the lat-th cycle after the IDLE cycle
  task automatic xact(input bit r, input bit w, input logic [31:0] addr,
                      input logic [31:0] wd, input int lat, input logic [31:0] sdata,
                      output int low, output logic [31:0] fin);
    bit busy, got;
    busy = w || !bc_lookup(word_of(addr));
    reset_mon();
    mem_r_en = r; mem_w_en = w; address = addr; wdata = wd;
    low = 0; got = 0; fin = '0;
    for (int c = 0; c < 64 && !got; c++) begin
      sram_ready = busy && (c == lat);
      sram_rdata = sdata;
      @(negedge clk);
      if (ready) begin got = 1; fin = rdata; end
      else low++;
      @(posedge clk); #1;
    end
    sram_ready = 0; mem_r_en = 0; mem_w_en = 0;
    if (!got) chk("ready_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    int          low;
    logic [31:0] fr;
    rst = 1; mem_r_en = 0; mem_w_en = 0; address = 32'h400; wdata = '0;
    sram_rdata = '0; sram_ready = 0;
    reset_mon();
    @(posedge clk); #1;
    chk_on = 1;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_hit_count", 32'(hit_count), 32'd0);
    chk("reset_miss_count", 32'(miss_count), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_enables", 32'({sram_rd_en, sram_wr_en, cache_wr_en, cache_rd_en}), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // Cold read of word 1, SRAM answers in 5 cycles
    xact(1, 0, 32'h404, '0, 5, 32'hDEADBEEF, low, fr);
    chk("cold_ready_low", 32'(low), 32'd6);
    chk("cold_rdata", fr, 32'hDEADBEEF);
    chk("cold_fill_pulses", 32'(n_cwr), 32'd1);
    chk("cold_fill_data", last_cwdata, 32'hDEADBEEF);
    chk("cold_sram_cycles", 32'(n_srd), 32'd5);
    chk("cold_miss_count", 32'(miss_count), 32'd1);

    // Repeat read hits with zero latency
    xact(1, 0, 32'h404, '0, 5, 32'h0, low, fr);
    chk("hit_ready_low", 32'(low), 32'd0);
    chk("hit_rdata", fr, 32'hDEADBEEF);
    chk("hit_rd_en", 32'(n_crd), 32'd1);
    chk("hit_count_1", 32'(hit_count), 32'd1);
    chk("hit_no_sram", 32'(n_srd + n_swr), 32'd0);

    // Write-through to the cached word
    xact(0, 1, 32'h404, 32'h12345678, 3, 32'h0, low, fr);
    chk("wr_invalidate", 32'(n_inv), 32'd1);
    chk("wr_sram_cycles", 32'(n_swr), 32'd3);
    chk("wr_sram_addr", last_saddr, 32'd1);
    chk("wr_sram_data", last_swdata, 32'h12345678);
    chk("wr_ready_low", 32'(low), 32'd4);

    // Invalidated word now misses
    xact(1, 0, 32'h404, '0, 2, 32'h12345678, low, fr);
    chk("reread_ready_low", 32'(low), 32'd3);
    chk("reread_miss_count", 32'(miss_count), 32'd2);
    chk("reread_rdata", fr, 32'h12345678);

    // Low address bits ignored
    xact(1, 0, 32'h407, '0, 2, 32'h0, low, fr);
    chk("lowbits_ready_low", 32'(low), 32'd0);
    chk("lowbits_rdata", fr, 32'h12345678);

    // Simultaneous read and write: write path, no miss counted
    xact(1, 1, 32'h408, 32'hAAAA5555, 2, 32'h0, low, fr);
    chk("rw_ready_low", 32'(low), 32'd3);
    chk("rw_miss_count", 32'(miss_count), 32'd2);
    chk("rw_no_read", 32'(n_srd), 32'd0);
    chk("rw_sram_cycles", 32'(n_swr), 32'd2);
    chk("rw_sram_addr", last_saddr, 32'd2);

    // Reset two cycles into READ_MISS
    reset_mon();
    mem_r_en = 1; address = 32'h800;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1; mem_r_en = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_sram_rd_en", 32'(sram_rd_en), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    chk("rst_no_fill", 32'(n_cwr), 32'd0);
    chk("rst_sram_cycles", 32'(n_srd), 32'd3);
    @(posedge clk); #1;

    // Hit counter saturation
    for (int i = 1; i <= 17; i++) begin
      xact(1, 0, 32'h404, '0, 2, 32'h0, low, fr);
      if (i == 15) chk("sat_hit_15", 32'(hit_count), 32'd15);
    end
    chk("sat_hit_17", 32'(hit_count), 32'd15);
    chk("sat_rdata", fr, 32'h12345678);
    chk("sat_miss_count", 32'(miss_count), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
